busdec: RTL

Registered multi-device bus address decoder with per-transaction handshake and response tracking. It sits between a single bus master and up to NDEV memory-mapped devices. It latches each request, decodes the address against a table of base addresses, and holds a one-hot device enable until the selected device signals ready. It then returns a one-cycle completion or error pulse to the master. Unmapped addresses and, optionally, stalled devices produce a bus error instead of hanging the bus.

---
 rtl/busdec.sv | 99 +++++++++
 1 files changed

// File: rtl/busdec.sv
// busdec: registered one-hot bus address decoder with ready handshake; define BUSDEC_TIMEOUT_EN for a TMO-cycle stall timeout
module busdec #(
    parameter int NDEV = 4,
    parameter int MASK = 12,
    parameter logic [NDEV*(32-MASK)-1:0] BASES = '0,
    parameter int TMO = 15,
    localparam int SW = NDEV > 1 ? $clog2(NDEV) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [31:0]     addr,
    output logic            busy,
    output logic [NDEV-1:0] deven,
    output logic [MASK-1:0] devaddr,
    output logic [SW-1:0]   devsel,
    input  logic [NDEV-1:0] devrdy,
    output logic            done,
    output logic            err
);
    localparam int BW = 32 - MASK;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t          state_q, state_d;
    logic [NDEV-1:0] deven_q, deven_d;
    logic [SW-1:0]   devsel_q, devsel_d, hit_idx;
    logic [MASK-1:0] devaddr_q, devaddr_d;
    logic            done_q, done_d, err_q, err_d, hit, timeout, rdy;
`ifdef BUSDEC_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign timeout = cnt_q == CW'(TMO - 1);
    always_comb cnt_d = state_q == ACCESS ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign timeout = 1'b0;
`endif
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (addr[31:MASK] == BASES[i*BW +: BW]) begin
                hit = 1'b1;
                hit_idx = SW'(i);
            end
    end
    assign rdy = devrdy[devsel_q];
    always_comb begin
        state_d = state_q;
        deven_d = deven_q;
        devsel_d = devsel_q;
        devaddr_d = devaddr_q;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                devaddr_d = addr[MASK-1:0];
                state_d = hit ? ACCESS : RESP;
                err_d = !hit;
                if (hit) begin
                    devsel_d = hit_idx;
                    deven_d[hit_idx] = 1'b1;
                end
            end
            ACCESS: if (rdy || timeout) begin
                state_d = RESP;
                deven_d = '0;
                done_d = rdy;
                err_d = !rdy;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= IDLE;
            deven_q <= '0;
            devsel_q <= '0;
            devaddr_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            deven_q <= deven_d;
            devsel_q <= devsel_d;
            devaddr_q <= devaddr_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    assign busy = state_q != IDLE;
    assign deven = deven_q;
    assign devsel = devsel_q;
    assign devaddr = devaddr_q;
    assign done = done_q;
    assign err = err_q;
endmodule
